// File: rtl/temple_run_pkg.sv
// Shared constants, gap base table and FSM state encoding for the obstacle spawner.
package temple_run_pkg;

   localparam int TRACK_ROWS = 16;
   localparam int LANES      = 3;
   localparam int TRACK_W    = TRACK_ROWS * LANES;
   localparam int GAP_W      = 4;

   // Gap counter value held after reset, before any clear or reload.
   localparam logic [GAP_W-1:0] GAP_RESET = 4'd6;

   // Base spawn gap indexed by difficulty: 0 -> 6, 1 -> 4, 2 -> 3, 3 -> 2.
   localparam logic [3:0][GAP_W-1:0] GAP_BASE = {4'd2, 4'd3, 4'd4, 4'd6};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GAP   = 2'd1,
      ST_SPAWN = 2'd2
   } state_e;

endpackage

// File: rtl/spawn_gap_counter.sv
// Down-counter for the number of empty frames between spawns.
// Clear loads the bare difficulty base; a non-empty spawn reloads base plus
// a two-bit random extension; GAP frames count down toward one.
module spawn_gap_counter
   import temple_run_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load_base_i,
   input  logic             reload_i,
   input  logic             dec_i,
   input  logic [1:0]       difficulty_i,
   input  logic [1:0]       rand_i,
   output logic [GAP_W-1:0] cnt_o,
   output logic             last_o
);

   logic [GAP_W-1:0] cnt_q;
   logic [GAP_W-1:0] cnt_d;

   // Next count: clear beats reload, reload beats decrement; never wraps below zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_base_i) begin
         cnt_d = GAP_BASE[difficulty_i];
      end else if (reload_i) begin
         cnt_d = GAP_BASE[difficulty_i] + {2'b00, rand_i};
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= GAP_RESET;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign last_o = (cnt_q == 4'd1);

endmodule

// File: rtl/obstacle_spawner.sv
// Obstacle track generator: 16-row x 3-lane shift register fed by a spawn FSM,
// with player-row collision pulse and a saturating passed-row counter.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | game paused (enable=0); track and counters frozen
//   ST_GAP   | feeding empty rows, gap counter counting down per frame
//   ST_SPAWN | feeding random row; empty mask retries next frame
module obstacle_spawner
   import temple_run_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [19:0]        random_number,
   input  logic               tick,
   input  logic               enable,
   input  logic               clear,
   input  logic [1:0]         difficulty,
   input  logic [1:0]         player_lane,
   output logic [TRACK_W-1:0] track,
   output logic               collision,
   output logic [15:0]        passed_count
);

   logic [1:0]         ready_q;
   logic               ready;
   logic               step;
   logic               do_clear;
   logic               advance;

   state_e             state_q;
   state_e             state_d;
   logic [TRACK_W-1:0] track_q;
   logic [TRACK_W-1:0] track_d;
   logic               collision_q;
   logic               collision_d;
   logic [15:0]        passed_count_q;
   logic [15:0]        passed_count_d;

   logic [2:0]         mask;
   logic [1:0]         sel;
   logic [2:0]         spawn_row;
   logic [2:0]         new_row;
   logic [2:0]         row14;
   logic [2:0]         row15;
   logic [1:0]         lane_eff;

   logic [GAP_W-1:0]   gap_cnt;
   logic               gap_last;
   logic               gap_reload;
   logic               gap_dec;

   // Only the low seven random bits are meaningful to the spawner.
   logic               unused_rand_bits;
   assign unused_rand_bits = ^random_number[19:7];

   // Release of reset is retimed through two flops, so no frame can land
   // before the second rising edge after rst goes high.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ready_q <= 2'b00;
      end else begin
         ready_q <= {ready_q[0], 1'b1};
      end
   end

   assign ready    = ready_q[1];
   assign step     = ready & tick & enable;
   assign do_clear = ready & clear;
   assign advance  = step & ~do_clear;

   assign row14    = track_q[3*(TRACK_ROWS-2) +: LANES];
   assign row15    = track_q[3*(TRACK_ROWS-1) +: LANES];
   assign lane_eff = (player_lane == 2'd3) ? 2'd1 : player_lane;

   // Spawn candidate: a full mask has one lane knocked out so the player
   // always has an escape; selector 3 folds onto lane 0.
   always_comb begin
      mask      = random_number[2:0];
      sel       = (random_number[4:3] == 2'd3) ? 2'd0 : random_number[4:3];
      spawn_row = mask;
      if (mask == 3'b111) begin
         spawn_row[sel] = 1'b0;
      end
      new_row = (state_q == ST_SPAWN) ? spawn_row : 3'b000;
   end

   assign gap_reload = advance & (state_q == ST_SPAWN) & (spawn_row != 3'b000);
   assign gap_dec    = advance & (state_q == ST_GAP);

   spawn_gap_counter u_gap (
      .clk          (clk),
      .rst          (rst),
      .load_base_i  (do_clear),
      .reload_i     (gap_reload),
      .dec_i        (gap_dec),
      .difficulty_i (difficulty),
      .rand_i       (random_number[6:5]),
      .cnt_o        (gap_cnt),
      .last_o       (gap_last)
   );

   // Next FSM state; clear wins over a same-cycle frame, disable parks in IDLE.
   always_comb begin
      state_d = state_q;
      if (!ready) begin
         state_d = state_q;
      end else if (do_clear) begin
         state_d = enable ? ST_GAP : ST_IDLE;
      end else if (!enable) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:  state_d = ST_GAP;
            ST_GAP:   if (step && gap_last) state_d = ST_SPAWN;
            ST_SPAWN: if (step && (spawn_row != 3'b000)) state_d = ST_GAP;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // Track shift, collision pulse and passed counter for the coming edge.
   always_comb begin
      track_d        = track_q;
      collision_d    = 1'b0;
      passed_count_d = passed_count_q;
      if (do_clear) begin
         track_d        = '0;
         passed_count_d = '0;
      end else if (advance) begin
         track_d     = {track_q[TRACK_W-LANES-1:0], new_row};
         collision_d = row14[lane_eff];
         if ((row15 != 3'b000) && (passed_count_q != 16'hFFFF)) begin
            passed_count_d = passed_count_q + 16'd1;
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= ST_IDLE;
         track_q        <= '0;
         collision_q    <= 1'b0;
         passed_count_q <= '0;
      end else begin
         state_q        <= state_d;
         track_q        <= track_d;
         collision_q    <= collision_d;
         passed_count_q <= passed_count_d;
      end
   end

   assign track        = track_q;
   assign collision    = collision_q;
   assign passed_count = passed_count_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Directed bench for obstacle_spawner with hand-computed expectations.
module tb_obstacle_spawner;
   import temple_run_pkg::*;

   logic        clk;
   logic        rst;
   logic [19:0] random_number;
   logic        tick;
   logic        enable;
   logic        clear;
   logic [1:0]  difficulty;
   logic [1:0]  player_lane;
   logic [47:0] track;
   logic        collision;
   logic [15:0] passed_count;

   int checks   = 0;
   int failures = 0;

   obstacle_spawner u_dut (
      .clk           (clk),
      .rst           (rst),
      .random_number (random_number),
      .tick          (tick),
      .enable        (enable),
      .clear         (clear),
      .difficulty    (difficulty),
      .player_lane   (player_lane),
      .track         (track),
      .collision     (collision),
      .passed_count  (passed_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One frame: tick high across exactly one rising edge; returns at the next falling edge.
   task automatic do_step();
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   initial begin
      rst           = 1'b0;
      random_number = 20'h0;
      tick          = 1'b0;
      enable        = 1'b0;
      clear         = 1'b0;
      difficulty    = 2'd0;
      player_lane   = 2'd0;

      repeat (2) @(negedge clk);
      chk("rst_track",  track, 48'h0);
      chk("rst_coll",   48'(collision), 48'h0);
      chk("rst_passed", 48'(passed_count), 48'h0);
      chk("rst_state",  48'(u_dut.state_q), 48'(ST_IDLE));
      chk("rst_gap",    48'(u_dut.u_gap.cnt_q), 48'd6);

      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_hold", 48'(u_dut.state_q), 48'(ST_IDLE));

      enable     = 1'b1;
      difficulty = 2'd3;
      @(negedge clk);
      chk("en_gap_state", 48'(u_dut.state_q), 48'(ST_GAP));
      chk("en_gap_cnt",   48'(u_dut.u_gap.cnt_q), 48'd6);

      // Empty mask keeps the FSM in SPAWN with nothing entering the track.
      do_clear();
      chk("clr_gap_base", 48'(u_dut.u_gap.cnt_q), 48'd2);
      random_number = 20'h00000;
      repeat (2) do_step();
      chk("zero_enter_spawn", 48'(u_dut.state_q), 48'(ST_SPAWN));
      repeat (5) do_step();
      chk("zero_track",  track, 48'h0);
      chk("zero_state",  48'(u_dut.state_q), 48'(ST_SPAWN));
      chk("zero_passed", 48'(passed_count), 48'h0);
      chk("zero_gap",    48'(u_dut.u_gap.cnt_q), 48'd0);

      // Full mask, sel=0: lane 0 knocked out, gap reload 2+0.
      do_clear();
      chk("clr_from_spawn", 48'(u_dut.state_q), 48'(ST_GAP));
      random_number = 20'h00007;
      do_step();
      chk("b_s1_gap", 48'(u_dut.u_gap.cnt_q), 48'd1);
      chk("b_s1_track", track, 48'h0);
      do_step();
      chk("b_s2_state", 48'(u_dut.state_q), 48'(ST_SPAWN));
      do_step();
      chk("b_spawn_row", track, 48'h6);
      chk("b_spawn_state", 48'(u_dut.state_q), 48'(ST_GAP));
      chk("b_gap_reload", 48'(u_dut.u_gap.cnt_q), 48'd2);

      // Row 001 travels to the player row; spawns repeat every third frame.
      do_clear();
      random_number = 20'h00001;
      player_lane   = 2'd0;
      repeat (2) do_step();
      do_step();                      // S1: spawn 001 into row 0
      chk("c_s1_track", track, 48'h1);
      repeat (14) do_step();          // S2..S15
      chk("c_s15_coll", 48'(collision), 48'h0);
      do_step();                      // S16
      chk("c_s16_coll",   48'(collision), 48'h1);
      chk("c_s16_passed", 48'(passed_count), 48'h0);
      @(negedge clk);
      chk("c_coll_pulse_end", 48'(collision), 48'h0);
      do_step();                      // S17
      chk("c_s17_passed", 48'(passed_count), 48'h1);
      chk("c_s17_coll",   48'(collision), 48'h0);
      player_lane = 2'd3;
      repeat (2) do_step();           // S18, S19: lane 3 acts as lane 1
      chk("c_lane3_coll", 48'(collision), 48'h0);
      do_step();                      // S20
      chk("c_s20_passed", 48'(passed_count), 48'h2);

      // Saturation: preload near the top, then more non-empty passes.
      force u_dut.passed_count_q = 16'hFFFE;
      #1 release u_dut.passed_count_q;
      repeat (3) do_step();           // S21..S23, S23 shifts out S7's row
      chk("sat_reach", 48'(passed_count), 48'hFFFF);
      repeat (3) do_step();           // S24..S26, S26 shifts out S10's row
      chk("sat_hold", 48'(passed_count), 48'hFFFF);

      // Clear together with a frame: no shift, everything zeroed.
      clear = 1'b1;
      tick  = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      tick  = 1'b0;
      chk("e_track",  track, 48'h0);
      chk("e_state",  48'(u_dut.state_q), 48'(ST_GAP));
      chk("e_passed", 48'(passed_count), 48'h0);
      chk("e_gap",    48'(u_dut.u_gap.cnt_q), 48'd2);

      // Difficulty change applies only at the next reload; sel=3 folds to lane 0.
      difficulty    = 2'd0;
      random_number = 20'h0001F;
      do_step();
      chk("d_dec_not_reload", 48'(u_dut.u_gap.cnt_q), 48'd1);
      repeat (2) do_step();
      chk("d_sel3_row", track, 48'h6);
      chk("d_reload6",  48'(u_dut.u_gap.cnt_q), 48'd6);

      // Async reset while in SPAWN with a populated track.
      random_number = 20'h00000;
      repeat (6) do_step();
      chk("f_pre_state", 48'(u_dut.state_q), 48'(ST_SPAWN));
      chk("f_pre_track", track, 48'h180000);
      #2 rst = 1'b0;
      #1;
      chk("f_rst_track",  track, 48'h0);
      chk("f_rst_coll",   48'(collision), 48'h0);
      chk("f_rst_passed", 48'(passed_count), 48'h0);
      chk("f_rst_state",  48'(u_dut.state_q), 48'(ST_IDLE));
      chk("f_rst_gap",    48'(u_dut.u_gap.cnt_q), 48'd6);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/obstacle_spawner.md
OBSTACLE_SPAWNER -- requirements
Module: obstacle_spawner

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset (0 = reset).
REQ-003 SHALL have port random_number, input, 20, pseudo-random word from the upstream generator; sampled only on tick.
REQ-004 SHALL have port tick, input, 1, one-cycle game-frame pulse; advances the track.
REQ-005 SHALL have port enable, input, 1, game running; 0 freezes all state.
REQ-006 SHALL have port clear, input, 1, synchronous restart of track and counters.
REQ-007 SHALL have port difficulty, input, 2, selects the base spawn gap.
REQ-008 SHALL have port player_lane, input, 2, player lane 0..2; value 3 treated as lane 1.
REQ-009 SHALL have port track, output, 48, 16 rows x 3 lane bits; row r at bits [3r+2:3r], row 0 = spawn (top), row 15 = player row.
REQ-010 SHALL have port collision, output, 1, one-cycle pulse on obstacle in the player lane of row 15.
REQ-011 SHALL have port passed_count, output, 16, saturating count of non-empty rows shifted out of row 15.

Function
REQ-012 SHALL act only when tick=1 and enable=1 ("step"); all other cycles hold state, except clear.
REQ-013 On step, SHALL shift rows 0..14 into rows 1..15 and load row 0 with new_row, in one cycle.
REQ-014 On step with old row 15 non-zero, SHALL increment passed_count, saturating at 0xFFFF.
REQ-015 SHALL implement FSM IDLE/GAP/SPAWN: IDLE while enable=0; enable=1 -> GAP; GAP on step with gap_cnt=1 -> SPAWN; SPAWN on next step -> GAP; enable=0 in any state -> IDLE, preserving track and counters.
REQ-016 In GAP, new_row SHALL be 000 and each step SHALL decrement gap_cnt.
REQ-017 In SPAWN, new_row SHALL be mask=random_number[2:0]; if mask=111, the lane sel=random_number[4:3] (3 maps to 0) SHALL be cleared, so no row blocks all lanes.
REQ-018 In SPAWN with mask=000, SHALL stay in SPAWN and retry on the next step, without gap reload.
REQ-019 On a non-empty spawn, gap_cnt SHALL reload with base+random_number[6:5]; base = 6/4/3/2 for difficulty 0/1/2/3.
REQ-020 After a step, collision SHALL pulse high exactly one cycle later iff new row 15 has the player_lane bit set; low otherwise.
REQ-021 clear=1 SHALL zero track, passed_count and collision, load gap_cnt with the difficulty base, and set state GAP (IDLE if enable=0); clear SHALL override a simultaneous step.
REQ-022 difficulty changes SHALL take effect only at the next gap reload.

Reset
REQ-023 rst=0 SHALL asynchronously force track=0, collision=0, passed_count=0, gap_cnt=6, state IDLE.
REQ-024 Reset release SHALL be synchronous to clk; first step no earlier than the second rising edge after release.
REQ-025 Reset mid-spawn SHALL discard the pending row; no partial shift is visible.

Structure
REQ-026 Package temple_run_pkg SHALL hold TRACK_ROWS=16, LANES=3, the gap base table, and the FSM state enum.
REQ-027 Gap reload and decrement SHALL live in one sub-module, spawn_gap_counter; shift register and FSM stay in obstacle_spawner.

Verification
REQ-028 Reset, enable=1, difficulty=3, random_number=0x00007, 3 steps -> first spawn lands at row 0 after the gap.
REQ-029 The same run -> spawned row 110 (lane 0 cleared, sel=0).
REQ-030 The same run -> gap_cnt reloads to 2+0=2.
REQ-031 random_number=0x00000 in SPAWN for 5 steps -> track stays 0, state stays SPAWN, passed_count=0.
REQ-032 Row 001 spawned, player_lane=0, 16 steps -> collision one-cycle pulse after the 16th step.
REQ-033 The same run -> passed_count increments on the 17th step.
REQ-034 passed_count preset to 0xFFFF via 65535 forced passes, one more non-empty pass -> stays 0xFFFF.
REQ-035 clear and tick asserted together with track non-zero -> track=0 next cycle, no shift, state GAP.
REQ-036 rst=0 asserted mid-cycle during SPAWN -> outputs zero immediately, before the next clk edge; state IDLE.
